// File: rtl/barcodescanner_video_pkg.sv
`default_nettype none
// ============================================================================
// Module   : barcodescanner_video_pkg
// Brief    : Shared frame geometry, RAM width and types for the video fetch.
// Revision : 1.0 - initial release
// ============================================================================
package barcodescanner_video_pkg;

   localparam int FRAME_WORDS     = 2500;
   localparam int LINE_PIXELS     = 100;
   localparam int PIXELS_PER_WORD = 4;
   localparam int RAM_AW          = 12;

   typedef logic [7:0] pixel_t;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/barcodescanner_video_word_fifo.sv
`default_nettype none
// ============================================================================
// Module   : barcodescanner_video_word_fifo
// Brief    : Two-entry word FIFO with first-word-fall-through head output.
// Revision : 1.0 - initial release
// ============================================================================
module barcodescanner_video_word_fifo
   import barcodescanner_video_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] r_mem [2];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (push) begin
            r_mem[r_wr_ptr] <= push_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({push, pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign head  = r_mem[r_rd_ptr];
   assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/barcodescanner_video_fetch.sv
`default_nettype none
// ============================================================================
// Module   : barcodescanner_video_fetch
// Brief    : Streams one frame of VideoRAM words as a byte-wide pixel stream
//            with sof/eol/eof flags. BARCODESCANNER_VIDEO_FETCH_PATTERN_EN
//            adds a (x+y) test-pattern source selected by pattern_sel.
// Revision : 1.0 - initial release
// ============================================================================
module barcodescanner_video_fetch
   import barcodescanner_video_pkg::*;
#(
   parameter int FRAME_WORDS = barcodescanner_video_pkg::FRAME_WORDS,
   parameter int LINE_PIXELS = barcodescanner_video_pkg::LINE_PIXELS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
`ifdef BARCODESCANNER_VIDEO_FETCH_PATTERN_EN
   input  logic              pattern_sel,
`endif
   output logic              busy,
   output logic              done,
   output logic [RAM_AW-1:0] ram_address,
   output logic              ram_chipselect,
   output logic              ram_clken,
   input  logic [31:0]       ram_readdata,
   output logic [7:0]        pix_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic              pix_sof,
   output logic              pix_eol,
   output logic              pix_eof
);

   localparam int c_PIX_TOTAL = PIXELS_PER_WORD * FRAME_WORDS;
   localparam int c_CW        = $clog2(c_PIX_TOTAL);
   localparam int c_XW        = $clog2(LINE_PIXELS);

   state_t            r_state;
   state_t            w_state_next;
   logic [RAM_AW-1:0] r_rd_addr;
   logic              r_rd_done;
   logic              r_inflight;
   logic              r_done;
   logic [1:0]        r_byte;
   logic [c_XW-1:0]   r_x;
   logic [c_CW-1:0]   r_y;
   logic [c_CW-1:0]   r_pix_cnt;
   logic [31:0]       w_head;
   logic [1:0]        w_count;
   logic              w_valid;
   logic              w_issue;
   logic              w_hs;
   logic              w_last_pix;
   logic              w_eof_hs;
   logic              w_pop;
   pixel_t            w_ram_pix;
   pixel_t            w_pix;

   barcodescanner_video_word_fifo #(
      .WIDTH (32)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (r_inflight),
      .push_data (ram_readdata),
      .pop       (w_pop),
      .head      (w_head),
      .count     (w_count)
   );

   // Occupancy plus the outstanding read must leave room for the return.
   assign w_valid    = (r_state == S_RUN) && (w_count != 2'd0);
   assign w_issue    = (r_state == S_RUN) && !r_rd_done &&
                       ((w_count + {1'b0, r_inflight}) < 2'd2);
   assign w_hs       = w_valid && pix_ready;
   assign w_last_pix = (r_pix_cnt == c_CW'(c_PIX_TOTAL - 1));
   assign w_eof_hs   = w_hs && w_last_pix;
   assign w_pop      = w_hs && (r_byte == 2'd3);

   always_comb begin
      w_ram_pix = w_head[7:0];
      case (r_byte)
         2'd1:    w_ram_pix = w_head[15:8];
         2'd2:    w_ram_pix = w_head[23:16];
         2'd3:    w_ram_pix = w_head[31:24];
         default: w_ram_pix = w_head[7:0];
      endcase
   end

`ifdef BARCODESCANNER_VIDEO_FETCH_PATTERN_EN
   logic   r_pattern;
   pixel_t w_pat_pix;

   // Pattern frames still run the read scheduler so timing matches RAM frames.
   assign w_pat_pix      = pixel_t'(32'(r_x) + 32'(r_y));
   assign w_pix          = r_pattern ? w_pat_pix : w_ram_pix;
   assign ram_chipselect = w_issue && !r_pattern;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pattern <= 1'b0;
      end else if ((r_state == S_IDLE) && start) begin
         r_pattern <= pattern_sel;
      end
   end
`else
   assign w_pix          = w_ram_pix;
   assign ram_chipselect = w_issue;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start)    w_state_next = S_RUN;
         S_RUN:   if (w_eof_hs) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_addr  <= '0;
         r_rd_done  <= 1'b0;
         r_inflight <= 1'b0;
         r_done     <= 1'b0;
         r_byte     <= 2'd0;
         r_x        <= '0;
         r_y        <= '0;
         r_pix_cnt  <= '0;
      end else begin
         r_inflight <= w_issue;
         r_done     <= w_eof_hs;
         if (r_state == S_IDLE) begin
            r_rd_addr <= '0;
            r_rd_done <= 1'b0;
            r_byte    <= 2'd0;
            r_x       <= '0;
            r_y       <= '0;
            r_pix_cnt <= '0;
         end else begin
            if (w_issue) begin
               if (r_rd_addr == RAM_AW'(FRAME_WORDS - 1)) begin
                  r_rd_done <= 1'b1;
               end else begin
                  r_rd_addr <= r_rd_addr + RAM_AW'(1);
               end
            end
            if (w_hs) begin
               r_byte    <= r_byte + 2'd1;
               r_pix_cnt <= r_pix_cnt + c_CW'(1);
               if (r_x == c_XW'(LINE_PIXELS - 1)) begin
                  r_x <= '0;
                  r_y <= r_y + c_CW'(1);
               end else begin
                  r_x <= r_x + c_XW'(1);
               end
            end
            if (w_eof_hs) begin
               r_rd_addr <= '0;
            end
         end
      end
   end

   assign busy        = (r_state == S_RUN);
   assign done        = r_done;
   assign ram_address = r_rd_addr;
   assign ram_clken   = 1'b1;
   assign pix_valid   = w_valid;
   assign pix_data    = w_valid ? w_pix : 8'h00;
   assign pix_sof     = w_valid && (r_pix_cnt == '0);
   assign pix_eol     = w_valid && (r_x == c_XW'(LINE_PIXELS - 1));
   assign pix_eof     = w_valid && w_last_pix;

endmodule
`default_nettype wire

// File: tb/tb_barcodescanner_video_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_barcodescanner_video_fetch
// Brief    : Randomized self-checking bench with a frame-level pixel model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_barcodescanner_video_fetch;

   localparam int FW    = 2500;
   localparam int LP    = 100;
   localparam int TOTAL = 4 * FW;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        pix_ready = 1'b1;
   logic        busy, done, ram_chipselect, ram_clken;
   logic        pix_valid, pix_sof, pix_eol, pix_eof;
   logic [11:0] ram_address;
   logic [31:0] ram_readdata;
   logic [7:0]  pix_data;
`ifdef BARCODESCANNER_VIDEO_FETCH_PATTERN_EN
   logic        pattern_sel = 1'b0;
`endif

   logic [31:0] mem [FW];
   int n_chk = 0;
   int n_fail = 0;
   int mode = 0;

   bit         busy_m, done_m, pat_m, p_pat, p_start, p_last_hs, p_stall;
   bit         p_reset = 1'b1;
   logic [7:0] p_data;
   logic [2:0] p_flags;
   int idx, addr_m, cyc, hs_cnt, eol_cnt, eof_at, max_addr, done_cnt, pat_pix;

   barcodescanner_video_fetch dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
`ifdef BARCODESCANNER_VIDEO_FETCH_PATTERN_EN
      .pattern_sel    (pattern_sel),
`endif
      .busy           (busy),
      .done           (done),
      .ram_address    (ram_address),
      .ram_chipselect (ram_chipselect),
      .ram_clken      (ram_clken),
      .ram_readdata   (ram_readdata),
      .pix_data       (pix_data),
      .pix_valid      (pix_valid),
      .pix_ready      (pix_ready),
      .pix_sof        (pix_sof),
      .pix_eol        (pix_eol),
      .pix_eof        (pix_eof)
   );

   always #5 clk = ~clk;

   // One-cycle read latency; garbage on the bus whenever no read was issued.
   always @(posedge clk) begin
      if (ram_chipselect && (int'(ram_address) < FW))
         ram_readdata <= mem[int'(ram_address)];
      else
         ram_readdata <= $urandom();
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         pix_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   function automatic logic [7:0] exp_pix(input int i);
      logic [31:0] w;
      if (pat_m) return 8'((i % LP) + (i / LP));
      w = mem[i / 4];
      return w[8 * (i % 4) +: 8];
   endfunction

   // Frame-level model: pixel i is byte i%4 of word i/4, at x=i%LP, y=i/LP.
   initial begin
      forever begin
         @(negedge clk);
         if (p_reset) begin
            busy_m = 0; done_m = 0; idx = 0; addr_m = 0; cyc = 0;
         end else begin
            done_m = p_last_hs;
            if (p_last_hs) begin
               busy_m = 0;
            end else if (!busy_m && p_start) begin
               busy_m = 1; idx = 0; addr_m = 0; cyc = 0; pat_m = p_pat;
               hs_cnt = 0; eol_cnt = 0; eof_at = -1; max_addr = 0; done_cnt = 0;
            end else if (busy_m) begin
               cyc++;
            end
         end

         chk("busy", busy, busy_m);
         chk("done", done, done_m);
         chk("ram_clken", ram_clken, 1);
         if (done) done_cnt++;
         if (p_reset) begin
            chk("rst_cs", ram_chipselect, 0);
            chk("rst_addr", ram_address, 0);
            chk("rst_valid", pix_valid, 0);
            chk("rst_data", pix_data, 0);
            chk("rst_flags", {pix_sof, pix_eol, pix_eof}, 0);
         end
         if (!busy_m) begin
            chk("idle_cs", ram_chipselect, 0);
            chk("idle_valid", pix_valid, 0);
         end
         if (busy_m && cyc == 0) begin
            chk("lat_addr", ram_address, 0);
            chk("lat_cs", ram_chipselect, pat_m ? 0 : 1);
         end
         if (busy_m && cyc < 2) chk("lat_novalid", pix_valid, 0);
         if (busy_m && cyc == 2) chk("lat_valid", pix_valid, 1);
         if (busy_m && mode == 0 && cyc >= 2 && idx < TOTAL)
            chk("no_bubble", pix_valid, 1);
         if (pat_m && busy_m) chk("pat_cs", ram_chipselect, 0);
         if (ram_chipselect) begin
            chk("rd_addr", ram_address, addr_m);
            chk("rd_room", (addr_m - idx / 4) <= 1, 1);
            if (int'(ram_address) > max_addr) max_addr = int'(ram_address);
            addr_m++;
         end
         if (p_stall && !p_reset) begin
            chk("stall_valid", pix_valid, 1);
            chk("stall_data", pix_data, p_data);
            chk("stall_flags", {pix_sof, pix_eol, pix_eof}, p_flags);
         end
         if (pix_valid) begin
            if (idx >= TOTAL) begin
               chk("pix_overrun", idx, TOTAL - 1);
            end else begin
               chk("pix_data", pix_data, exp_pix(idx));
               chk("pix_sof", pix_sof, idx == 0);
               chk("pix_eol", pix_eol, (idx % LP) == LP - 1);
               chk("pix_eof", pix_eof, idx == TOTAL - 1);
            end
         end

         p_last_hs = busy_m && pix_valid && pix_ready && (idx == TOTAL - 1);
         if (pix_valid && pix_ready) begin
            hs_cnt++;
            if (pix_eol) eol_cnt++;
            if (pix_eof) eof_at = idx;
            if (idx == 2 * LP + 3) pat_pix = int'(pix_data);
            idx++;
         end
         p_stall = pix_valid && !pix_ready;
         p_data  = pix_data;
         p_flags = {pix_sof, pix_eol, pix_eof};
         p_reset = reset;
         p_start = start;
`ifdef BARCODESCANNER_VIDEO_FETCH_PATTERN_EN
         p_pat   = pattern_sel;
`else
         p_pat   = 1'b0;
`endif
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic fill_mem();
      for (int i = 0; i < FW; i++) mem[i] = $urandom();
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", done, 1);
      tick(4);
   endtask

   task automatic wait_pix(input int target, input int budget);
      int n = 0;
      while (hs_cnt < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("pix_progress", hs_cnt >= target, 1);
      tick(1);
   endtask

   task automatic check_frame(input bit pattern);
      chk("frame_pixels", hs_cnt, TOTAL);
      chk("frame_eols", eol_cnt, TOTAL / LP);
      chk("frame_eof_at", eof_at, TOTAL - 1);
      chk("frame_max_addr", max_addr, pattern ? 0 : FW - 1);
      chk("frame_done_pulses", done_cnt, 1);
   endtask

   initial begin
      fill_mem();
      mem[0] = 32'h44332211;
      tick(3);
      reset = 1'b0;
      tick(2);

      // Literal first-word latency and byte order.
      pulse_start();
      @(negedge clk);
      chk("t1_addr0", ram_address, 0);
      chk("t1_cs0", ram_chipselect, 1);
      @(negedge clk);
      chk("t1_valid_t2", pix_valid, 0);
      @(negedge clk);
      chk("t1_pix0", pix_data, 8'h11);
      chk("t1_sof0", pix_sof, 1);
      @(negedge clk);
      chk("t1_pix1", pix_data, 8'h22);
      chk("t1_sof1", pix_sof, 0);
      @(negedge clk);
      chk("t1_pix2", pix_data, 8'h33);
      @(negedge clk);
      chk("t1_pix3", pix_data, 8'h44);
      wait_done(20000);
      check_frame(1'b0);

      // Random backpressure at roughly 30% ready.
      fill_mem();
      mode = 1;
      tick(3);
      pulse_start();
      wait_done(60000);
      check_frame(1'b0);
      mode = 0;
      tick(3);

      // Start mid-frame is ignored.
      fill_mem();
      pulse_start();
      wait_pix(500, 2000);
      pulse_start();
      wait_done(20000);
      check_frame(1'b0);

      // Reset mid-frame, then a clean frame from address 0.
      pulse_start();
      wait_pix(5000, 20000);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      fill_mem();
      tick(3);
      chk("abort_busy", busy, 0);
      pulse_start();
      @(negedge clk);
      chk("t4_addr0", ram_address, 0);
      chk("t4_cs0", ram_chipselect, 1);
      @(negedge clk);
      @(negedge clk);
      chk("t4_sof0", pix_sof, 1);
      chk("t4_pix0", pix_data, {24'h0, mem[0][7:0]});
      wait_done(20000);
      check_frame(1'b0);

`ifdef BARCODESCANNER_VIDEO_FETCH_PATTERN_EN
      pattern_sel = 1'b1;
      tick(2);
      pulse_start();
      pattern_sel = 1'b0;
      wait_done(20000);
      check_frame(1'b1);
      chk("pat_x3_y2", pat_pix, 5);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/barcodescanner_video_fetch.md
BARCODESCANNER_VIDEO_FETCH -- requirements
Module: barcodescanner_video_fetch

Interface
REQ-001 SHALL have parameter FRAME_WORDS, default 2500, meaning the number of 32-bit words per frame.
REQ-002 SHALL have parameter LINE_PIXELS, default 100, meaning the number of pixels per line.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: a one-cycle request to stream one frame.
REQ-006 SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-007 SHALL have port done, output, 1 bit: a one-cycle pulse at frame completion.
REQ-008 SHALL have port ram_address, output, 12 bits: the word address to VideoRAM port 2.
REQ-009 SHALL have port ram_chipselect, output, 1 bit: a read strobe to VideoRAM port 2.
REQ-010 SHALL have port ram_clken, output, 1 bit: VideoRAM port 2 clock enable, tied high.
REQ-011 SHALL have port ram_readdata, input, 32 bits: port 2 read data, valid one cycle after address and chipselect are presented.
REQ-012 SHALL have port pix_data, output, 8 bits: the pixel value.
REQ-013 SHALL have port pix_valid, output, 1 bit: pixel stream valid.
REQ-014 SHALL have port pix_ready, input, 1 bit: downstream accept.
REQ-015 SHALL have port pix_sof, output, 1 bit: qualifies the first pixel of the frame.
REQ-016 SHALL have port pix_eol, output, 1 bit: qualifies the last pixel of a line.
REQ-017 SHALL have port pix_eof, output, 1 bit: qualifies the last pixel of the frame.

Function
REQ-018 States SHALL be IDLE and RUN; IDLE->RUN on start; RUN->IDLE on the handshake of the eof pixel; start while in RUN SHALL be ignored.
REQ-019 In RUN, reads SHALL issue sequentially for addresses 0..FRAME_WORDS-1, one per cycle at most, then stop; ram_chipselect SHALL be low at all other times.
REQ-020 A read SHALL issue only when FIFO occupancy plus in-flight reads is less than 2; the FIFO SHALL never overflow.
REQ-021 The returned word SHALL be written into a 2-entry word FIFO in the cycle ram_readdata is valid.
REQ-022 Each word SHALL emit 4 pixels in order: bits [7:0], [15:8], [23:16], [31:24].
REQ-023 A pixel SHALL transfer when pix_valid and pix_ready are both high; while pix_ready is low, pix_data and all flags SHALL hold stable and pix_valid SHALL stay high.
REQ-024 Latency: start sampled at edge T SHALL give ram_address=0 with ram_chipselect=1 during T+1, and the first pix_valid during T+3 when pix_ready is constantly high.
REQ-025 Throughput with pix_ready constantly high SHALL be 1 pixel per cycle with no bubbles after the first pixel.
REQ-026 x (0..LINE_PIXELS-1) and y counters SHALL advance per handshake; x SHALL wrap to 0 and y SHALL increment after x = LINE_PIXELS-1.
REQ-027 pix_sof SHALL be set at pixel 0; pix_eol SHALL be set when x = LINE_PIXELS-1; pix_eof SHALL be set at pixel 4*FRAME_WORDS-1, coincident with pix_eol.
REQ-028 done SHALL pulse in the cycle after the eof handshake; busy SHALL fall in that same cycle; start in that cycle SHALL be accepted.

Reset
REQ-029 Reset SHALL, from any state including mid-frame, abort and go to IDLE, discard FIFO contents and in-flight reads, and clear all counters.
REQ-030 Reset values SHALL be: busy=0, done=0, ram_chipselect=0, ram_address=0, pix_valid=0, pix_data=0, and all flags=0.
REQ-031 A readdata return for a read issued before reset SHALL be ignored.

Configuration
REQ-032 Macro BARCODESCANNER_VIDEO_FETCH_PATTERN_EN, when defined, SHALL add input port pattern_sel (1 bit, sampled at start); with pattern_sel=1 the frame SHALL carry pix_data=(x+y) mod 256 with identical timing and flags and no RAM reads.
REQ-033 Without the macro, port pattern_sel SHALL be absent and RAM data SHALL always be streamed.

Structure
REQ-034 Package barcodescanner_video_pkg SHALL hold FRAME_WORDS, LINE_PIXELS, PIXELS_PER_WORD=4, RAM_AW=12, and the typedef pixel_t (8 bits).
REQ-035 The 2-entry FIFO SHALL be the sub-module barcodescanner_video_word_fifo.

Verification
REQ-036 Test: reset, start, pix_ready=1, RAM word0=0x44332211 -> ram_address=0 at T+1; pixels 0x11, 0x22, 0x33, 0x44 at T+3..T+6, with pix_sof on 0x11.
REQ-037 Test: full frame with pix_ready=1 -> 10000 pixels; pix_eol every 100th pixel; pix_eof at pixel 9999; done one cycle later; ram_address peaks at 2499.
REQ-038 Test: random pix_ready at 30% duty -> data stable while stalled, FIFO never overflows, output sequence equal to RAM bytes in order.
REQ-039 Test: start pulsed at pixel 500 -> ignored; the frame completes normally with a single done pulse.
REQ-040 Test: reset asserted at pixel 5000, then start -> the new frame begins at address 0 with pix_sof, and no stale pixels are emitted.
REQ-041 Test: with the macro defined and pattern_sel=1 -> ram_chipselect stays 0, pixel (x=3, y=2) = 5, and done fires after 10000 pixels.
